// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer.
// Unit multiples are in Morse time units.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_LGAP,
    ST_WGAP
  } state_t;

  localparam logic [4:0] LAST_LETTER = 5'd25;
  localparam logic [4:0] SPACE_CODE  = 5'd26;

  localparam logic [2:0] DOT  = 3'd1;
  localparam logic [2:0] DASH = 3'd3;
  localparam logic [2:0] LGAP = 3'd3;
  localparam logic [2:0] WGAP = 7'd7;

endpackage

// File: rtl/morse_rom.sv
// ITU Morse table: letter code -> symbol count and
// left-aligned pattern (1 = dash, MSB sent first).
module morse_rom (
  input  logic [4:0] i_letter,
  output logic [3:0] o_len,
  output logic [3:0] o_pat
);

  always_comb begin
    o_len = 4'd0;
    o_pat = 4'b0000;
    unique case (i_letter)
      5'd0:  begin o_len = 4'd2; o_pat = 4'b0100; end
      5'd1:  begin o_len = 4'd4; o_pat = 4'b1000; end
      5'd2:  begin o_len = 4'd4; o_pat = 4'b1010; end
      5'd3:  begin o_len = 4'd3; o_pat = 4'b1000; end
      5'd4:  begin o_len = 4'd1; o_pat = 4'b0000; end
      5'd5:  begin o_len = 4'd4; o_pat = 4'b0010; end
      5'd6:  begin o_len = 4'd3; o_pat = 4'b1100; end
      5'd7:  begin o_len = 4'd4; o_pat = 4'b0000; end
      5'd8:  begin o_len = 4'd2; o_pat = 4'b0000; end
      5'd9:  begin o_len = 4'd4; o_pat = 4'b0111; end
      5'd10: begin o_len = 4'd3; o_pat = 4'b1010; end
      5'd11: begin o_len = 4'd4; o_pat = 4'b0100; end
      5'd12: begin o_len = 4'd2; o_pat = 4'b1100; end
      5'd13: begin o_len = 4'd2; o_pat = 4'b1000; end
      5'd14: begin o_len = 4'd3; o_pat = 4'b1110; end
      5'd15: begin o_len = 4'd4; o_pat = 4'b0110; end
      5'd16: begin o_len = 4'd4; o_pat = 4'b1101; end
      5'd17: begin o_len = 4'd3; o_pat = 4'b0100; end
      5'd18: begin o_len = 4'd3; o_pat = 4'b0000; end
      5'd19: begin o_len = 4'd1; o_pat = 4'b1000; end
      5'd20: begin o_len = 4'd3; o_pat = 4'b0010; end
      5'd21: begin o_len = 4'd4; o_pat = 4'b0001; end
      5'd22: begin o_len = 4'd3; o_pat = 4'b0110; end
      5'd23: begin o_len = 4'd4; o_pat = 4'b1001; end
      5'd24: begin o_len = 4'd4; o_pat = 4'b1011; end
      5'd25: begin o_len = 4'd4; o_pat = 4'b1100; end
      default: begin o_len = 4'd0; o_pat = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: takes one character code per handshake and
// keys it out with standard dot/dash/gap timing.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       letter_valid,
  input  logic [4:0] letter,
  output logic       letter_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cyc, w_cyc;
  logic [2:0]    r_unit, w_unit;
  logic [2:0]    r_idx, w_idx;
  logic [3:0]    r_pat, w_pat;
  logic [3:0]    r_len, w_len;
  logic          r_done, w_done;
  logic          r_err, w_err;

  logic [3:0] w_rom_len;
  logic [3:0] w_rom_pat;
  logic       w_unit_end;
  logic       w_dash;
  logic [2:0] w_target;
  logic       w_span_end;

  morse_rom u_rom (
    .i_letter (letter),
    .o_len    (w_rom_len),
    .o_pat    (w_rom_pat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_unit  <= '0;
      r_idx   <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_unit  <= w_unit;
      r_idx   <= w_idx;
      r_pat   <= w_pat;
      r_len   <= w_len;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign w_unit_end = (r_cyc == CYC_LAST);
  assign w_dash     = |(r_pat & (4'b1000 >> r_idx));

  always_comb begin
    w_target = DOT;
    unique case (r_state)
      ST_MARK: w_target = w_dash ? DASH : DOT;
      ST_LGAP: w_target = LGAP;
      ST_WGAP: w_target = WGAP;
      default: w_target = DOT;
    endcase
  end

  assign w_span_end = w_unit_end && (r_unit == w_target - 3'd1);

  always_comb begin
    w_state = r_state;
    w_cyc   = w_unit_end ? '0 : r_cyc + CW'(1);
    w_unit  = w_unit_end ? r_unit + 3'd1 : r_unit;
    w_idx   = r_idx;
    w_pat   = r_pat;
    w_len   = r_len;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (w_span_end) begin
      w_cyc  = '0;
      w_unit = '0;
    end
    unique case (r_state)
      ST_IDLE: begin
        w_cyc  = '0;
        w_unit = '0;
        if (letter_valid) begin
          if (letter <= LAST_LETTER) begin
            w_state = ST_MARK;
            w_idx   = '0;
            w_pat   = w_rom_pat;
            w_len   = w_rom_len;
          end else if (letter == SPACE_CODE) begin
            w_state = ST_WGAP;
          end else begin
            w_err  = 1'b1;
            w_done = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (w_span_end) begin
          w_idx   = r_idx + 3'd1;
          w_state = ({1'b0, r_idx} + 4'd1 == r_len)
                    ? ST_LGAP : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_span_end) w_state = ST_MARK;
      end
      ST_LGAP, ST_WGAP: begin
        if (w_span_end) begin
          w_state = ST_IDLE;
          w_done  = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign letter_ready = (r_state == ST_IDLE);
  assign busy         = !letter_ready;
  assign key_out      = (r_state == ST_MARK);
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer at UNIT_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_morse_keyer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       letter_valid;
  logic [4:0] letter;
  logic       letter_ready;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [4:0] code;
    string      morse;
    int         done_at;
    bit         hv;
    logic [4:0] hl;
  } vec_t;

  vec_t tbl[12];

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .letter_valid (letter_valid),
    .letter       (letter),
    .letter_ready (letter_ready),
    .key_out      (key_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {key_out, busy, letter_ready, done, err}
  task automatic chk(input string nm, input logic [4:0] e);
    logic [4:0] got;
    got = {key_out, busy, letter_ready, done, err};
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, e);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] l,
                      input logic [4:0] e, input string nm);
    letter_valid = v;
    letter       = l;
    chk(nm, e);
    @(posedge clk);
    #1;
  endtask

  // Handshake at T, then checks T+1 .. T+done_at-1.
  task automatic run_vec(input vec_t t, input bit first_done);
    bit q[$];
    byte c;
    logic k;
    step(1'b1, t.code, {4'b0010, 1'b0} | {3'b0, first_done, 1'b0},
         {"hs_", t.morse});
    if (t.morse == "x") begin
      step(1'b0, 5'd0, 5'b00111, "illegal");
      return;
    end
    if (t.morse == "w") begin
      for (int i = 0; i < 7 * U; i++) q.push_back(1'b0);
    end else begin
      for (int i = 0; i < t.morse.len(); i++) begin
        c = t.morse[i];
        if (i > 0)
          for (int j = 0; j < U; j++) q.push_back(1'b0);
        for (int j = 0; j < ((c == "-") ? 3 : 1) * U; j++)
          q.push_back(1'b1);
      end
      for (int j = 0; j < 3 * U; j++) q.push_back(1'b0);
    end
    for (int kk = 1; kk < t.done_at; kk++) begin
      k = (kk - 1 < q.size()) ? q[kk-1] : 1'b0;
      step(t.hv, t.hl, {k, 4'b1000}, {"busy_", t.morse});
    end
  endtask

  initial begin
    tbl[0]  = '{5'd4,  ".",    17, 1'b0, 5'd0};
    tbl[1]  = '{5'd0,  ".-",   33, 1'b0, 5'd0};
    tbl[2]  = '{5'd19, "-",    25, 1'b0, 5'd0};
    tbl[3]  = '{5'd18, "...",  33, 1'b0, 5'd0};
    tbl[4]  = '{5'd14, "---",  57, 1'b0, 5'd0};
    tbl[5]  = '{5'd16, "--.-", 65, 1'b0, 5'd0};
    tbl[6]  = '{5'd25, "--..", 57, 1'b0, 5'd0};
    tbl[7]  = '{5'd26, "w",    29, 1'b0, 5'd0};
    tbl[8]  = '{5'd30, "x",    1,  1'b0, 5'd0};
    tbl[9]  = '{5'd27, "x",    1,  1'b0, 5'd0};
    tbl[10] = '{5'd31, "x",    1,  1'b0, 5'd0};
    tbl[11] = '{5'd4,  ".",    17, 1'b1, 5'd19};

    resetn       = 1'b0;
    letter_valid = 1'b0;
    letter       = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 5'b00100);
    resetn = 1'b1;
    step(1'b0, 5'd0, 5'b00100, "idle0");

    foreach (tbl[i]) begin
      run_vec(tbl[i], 1'b0);
      if (tbl[i].morse != "x")
        step(1'b0, 5'd0, 5'b00110, {"done_", tbl[i].morse});
      step(1'b0, 5'd0, 5'b00100, "idle_after");
    end

    // 'S' then 'O' with letter_valid held across the boundary
    begin
      vec_t s, o;
      s = '{5'd18, "...", 33, 1'b1, 5'd14};
      o = '{5'd14, "---", 57, 1'b0, 5'd0};
      run_vec(s, 1'b0);
      run_vec(o, 1'b1);
      step(1'b0, 5'd0, 5'b00110, "done_O_b2b");
      step(1'b0, 5'd0, 5'b00100, "idle_b2b");
    end

    // 'Q' aborted by reset during its second dash
    step(1'b1, 5'd16, 5'b00100, "hs_Q_rst");
    for (int kk = 1; kk <= 21; kk++)
      step(1'b0, 5'd0, {(kk <= 12 || kk >= 17), 4'b1000}, "q_pre_rst");
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", 5'b00100);
    @(posedge clk);
    #1;
    chk("rst_hold", 5'b00100);
    resetn = 1'b1;
    for (int kk = 0; kk < 6; kk++)
      step(1'b0, 5'd0, 5'b00100, "no_done_after_rst");
    run_vec(tbl[0], 1'b0);
    step(1'b0, 5'd0, 5'b00110, "done_E_after_rst");
    step(1'b0, 5'd0, 5'b00100, "idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
